// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-memory frontend for the fetch stage. Owns the instruction RAM,
//   lets a host load a program into it, and answers fetch requests with a
//   fixed READ_LATENCY-cycle pipeline. Responses have no backpressure and are
//   tagged with the address they were read from. A flush kills every request
//   accepted up to and including the flush cycle.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_addr/valid/ready fetch request handshake (accept = valid && ready)
//   rsp_data/addr/valid  response; rsp_valid is a one-cycle pulse, data/addr
//                        hold their last value otherwise
//   flush                kill all in-flight and same-cycle requests
//   load_start/done      enter / leave program-load mode
//   wr_en/addr/data      host RAM write, honoured only while loading
//   loading              high while draining or loading
//   inflight             accepted, not-yet-returned, unflushed requests
module imem_responder #(
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int INSTR_WIDTH     = 64,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IMEM_ADDR_WIDTH-1:0] req_addr,
  input  logic                       req_valid,
  output logic                       req_ready,
  output logic [INSTR_WIDTH-1:0]     rsp_data,
  output logic [IMEM_ADDR_WIDTH-1:0] rsp_addr,
  output logic                       rsp_valid,
  input  logic                       flush,
  input  logic                       load_start,
  input  logic                       load_done,
  input  logic                       wr_en,
  input  logic [IMEM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [INSTR_WIDTH-1:0]     wr_data,
  output logic                       loading,
  output logic [2:0]                 inflight
);

  localparam int DEPTH = 1 << IMEM_ADDR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_LOAD} state_e;

  state_e state_q, state_d;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  // Stage 0 of the data pipe is the registered RAM read; later stages delay
  // it so data and address line up with the valid bits.
  logic [READ_LATENCY-1:0][INSTR_WIDTH-1:0]     data_pipe_q;
  logic [READ_LATENCY-1:0][IMEM_ADDR_WIDTH-1:0] addr_pipe_q;
  logic [READ_LATENCY-1:0]                      vld_q, vld_d;

  logic                       rsp_valid_q, rsp_valid_d;
  logic [INSTR_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic [IMEM_ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [2:0]                 inflight_q, inflight_d;

  logic accept;
  logic ram_we;

  assign accept = req_valid && req_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_start) state_d = ST_LOAD;
      ST_RUN:   if (load_start) state_d = ST_DRAIN;
      // Checked every DRAIN cycle, so an empty pipe leaves on the entry cycle.
      ST_DRAIN: if (inflight_q == 3'd0) state_d = ST_LOAD;
      ST_LOAD:  if (load_done) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = 1'b0;
    loading   = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      // Drop ready in the load_start cycle itself so nothing slips in
      // behind the drain decision.
      ST_RUN:   req_ready = !load_start;
      ST_DRAIN: loading   = 1'b1;
      ST_LOAD: begin
        loading = 1'b1;
        ram_we  = wr_en;
      end
      default: ;
    endcase
  end

  // ---------------- RAM and data/address pipeline (no reset) ----------------
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_addr] <= wr_data;
    end
    if (accept) begin
      data_pipe_q[0] <= mem[req_addr];
      addr_pipe_q[0] <= req_addr;
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      data_pipe_q[i] <= data_pipe_q[i-1];
      addr_pipe_q[i] <= addr_pipe_q[i-1];
    end
  end

  // ---------------- valid pipeline, response and occupancy ----------------
  always_comb begin
    vld_d = '0;
    // Flush clears every stage including the one a same-cycle accept would fill.
    vld_d[0] = accept && !flush;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1] && !flush;
    end

    rsp_valid_d = vld_q[READ_LATENCY-1] && !flush;
    rsp_data_d  = rsp_valid_d ? data_pipe_q[READ_LATENCY-1] : rsp_data_q;
    rsp_addr_d  = rsp_valid_d ? addr_pipe_q[READ_LATENCY-1] : rsp_addr_q;

    // A request stops counting when it moves into the response register,
    // which caps the count at READ_LATENCY.
    if (flush) begin
      inflight_d = 3'd0;
    end else begin
      inflight_d = inflight_q + {2'b00, accept} - {2'b00, vld_q[READ_LATENCY-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      inflight_q  <= 3'd0;
    end else begin
      vld_q       <= vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      inflight_q  <= inflight_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign inflight  = inflight_q;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory frontend that answers the fetch stage's instruction requests.
- Accepts a one-instruction-per-cycle address stream with a ready/valid request handshake. Returns each instruction with fixed pipeline latency, tagged with its address, and with no response backpressure.
- Owns the instruction RAM and arbitrates between host program loading and fetch traffic. Supports a flush that kills in-flight responses on redirect.

Parameters:
- IMEM_ADDR_WIDTH, 10, instruction-indexed address width (one address = one instruction); depth = 2**IMEM_ADDR_WIDTH.
- INSTR_WIDTH, 64, instruction word width.
- READ_LATENCY, 2, request-accept to response-valid cycles; legal range 1..4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_addr  in  IMEM_ADDR_WIDTH  fetch address.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_data  out  INSTR_WIDTH  returned instruction.
- rsp_addr  out  IMEM_ADDR_WIDTH  address the instruction was read from.
- rsp_valid  out  1  response valid; the consumer always accepts it.
- flush  in  1  kill all requests accepted before this cycle.
- load_start  in  1  host requests program-load mode.
- load_done  in  1  host ends program-load mode.
- wr_en  in  1  host instruction write.
- wr_addr  in  IMEM_ADDR_WIDTH  host write address.
- wr_data  in  INSTR_WIDTH  host write data.
- loading  out  1  high in DRAIN or LOAD states.
- inflight  out  3  count of accepted, not-yet-returned, unflushed requests.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_addr = 0.
  - inflight = 0, loading = 0, all pipeline valid bits = 0.
  - RAM contents are not reset.
  - Reset mid-operation discards all in-flight requests; no response appears after rst_n rises.
- States:
  - IDLE: no program. req_ready = 0. load_start -> LOAD.
  - RUN: req_ready = 1. load_start -> DRAIN, and req_ready drops in that same cycle (combinational on load_start).
  - DRAIN: req_ready = 0. Leaves for LOAD when inflight == 0, including the entry cycle if already 0.
  - LOAD: req_ready = 0. wr_en writes the RAM. load_done -> RUN on the next cycle. If load_done and wr_en occur together, the write is performed.
- wr_en is ignored outside LOAD. load_start is ignored in DRAIN and LOAD. load_done is ignored outside LOAD.
- Request accept: req_valid && req_ready. The accepted address enters pipeline stage 0.
- Response timing: exactly READ_LATENCY cycles after the accept edge, rsp_valid = 1 with rsp_data = RAM[addr] and rsp_addr = addr.
  - Back-to-back accepts yield back-to-back responses in request order.
  - Responses carry no bubbles beyond those in the request stream.
- rsp_valid is a single-cycle pulse per response. rsp_data and rsp_addr hold their last value when rsp_valid = 0.
- Flush:
  - Clears every pipeline valid bit on the next edge, so no response for any request accepted at or before the flush cycle is ever emitted.
  - A request accepted in the same cycle as flush is also killed.
  - The first request accepted after flush deasserts is served normally.
  - inflight becomes 0 on the edge after flush.
- inflight: +1 per accept, -1 per emitted response, both in the same cycle net 0. Maximum value is READ_LATENCY, so it never wraps.
- Address arithmetic: addresses are never incremented internally. Any req_addr value, including all-ones, is legal.
- Read-during-write cannot occur, because reads are blocked in LOAD.

Test Plan:
- Reset, LOAD, write RAM[0..3] = 0x10..0x13, load_done, then req_valid on addr 0,1,2,3 in consecutive cycles with READ_LATENCY = 2 -> rsp_valid high for 4 consecutive cycles, starting 2 cycles after the first accept, with data 0x10..0x13 and rsp_addr 0..3.
- In RUN, accept addr 5 then 6, assert flush in the cycle after addr 6 is accepted -> no responses for 5 or 6. inflight = 0. A request to 7 issued two cycles later returns RAM[7] with rsp_addr = 7.
- Issue 2 requests, then load_start in the next cycle -> req_ready = 0 immediately. Both responses still arrive. State enters LOAD only after inflight = 0, and loading = 1 throughout.
- Drop rst_n while 2 requests are in flight -> rsp_valid stays 0 through and after reset release. req_ready = 0 until a LOAD/load_done sequence completes.
- Request to addr 0x3FF (IMEM_ADDR_WIDTH = 10) -> rsp_addr = 0x3FF with the correct data. Also check that wr_en in RUN leaves RAM unchanged on a readback.
- Repeat the first scenario with READ_LATENCY = 1 and 4 -> responses appear exactly 1 and 4 cycles after accept, respectively.
